// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage:
//   - instruction field positions for Rs/Rt
//   - NOP encoding used to fill IF/ID on a bubble
//   - fetch state machine encoding
//   - default reset PC
//   - field-extraction helpers
package if_fetch_stage_pkg;

   localparam int unsigned RS_MSB = 25;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_MSB = 20;
   localparam int unsigned RT_LSB = 16;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   // S_REQ : issuing a fetch at PC
   // S_WAIT: one request outstanding, waiting for its response
   // S_HOLD: response parked in the skid buffer while the pipe is stalled
   // S_DROP: outstanding response belongs to a flushed path and is discarded
   typedef enum logic [1:0] {
      S_REQ  = 2'b00,
      S_WAIT = 2'b01,
      S_HOLD = 2'b10,
      S_DROP = 2'b11
   } fetch_state_e;

   function automatic logic [4:0] instr_rs(input logic [31:0] instr);
      return instr[RS_MSB:RS_LSB];
   endfunction

   function automatic logic [4:0] instr_rt(input logic [31:0] instr);
      return instr[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/if_fetch_stage_skid.sv
// if_skid_buffer
//   One-entry holding register for an instruction word and the address it
//   was fetched from. Used when a response arrives while ID is stalled.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     i_load      - capture i_data/i_pc and mark full
//     i_clear     - empty the buffer (wins over i_load)
//     i_data/i_pc - word and its fetch address
//     o_full      - buffer holds a word
//     o_data/o_pc - buffered word and address
module if_skid_buffer
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [31:0]       i_data,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_full,
   output logic [31:0]       o_data,
   output logic [ADDR_W-1:0] o_pc
);

   logic              r_full;
   logic [31:0]       r_data;
   logic [ADDR_W-1:0] r_pc;

   // Buffer storage: clear has priority so a flush never leaves a stale word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= NOP;
         r_pc   <= {ADDR_W{1'b0}};
      end else if (i_clear) begin
         r_full <= 1'b0;
         r_data <= NOP;
         r_pc   <= {ADDR_W{1'b0}};
      end else if (i_load) begin
         r_full <= 1'b1;
         r_data <= i_data;
         r_pc   <= i_pc;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;
   assign o_pc   = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction fetch plus IF/ID pipeline register. Owns the PC, issues one
//   fetch at a time over a valid/ready request channel, and places returned
//   words into IF/ID. Load_Use stalls (PC and IF/ID hold, in-flight word is
//   parked in a skid buffer); Redirect flushes (IF/ID bubble, PC reloaded,
//   any outstanding response is discarded).
//   Ports:
//     clk, rst_n                       - clock, asynchronous active-low reset
//     Load_Use                         - stall from load-use detector
//     Redirect, Redirect_PC            - taken branch/jump from ID
//     imem_req_valid/ready, imem_addr  - fetch request channel
//     imem_rsp_valid, imem_rsp_data    - in-order fetch response
//     Valid_IF_ID, Instr_IF_ID         - IF/ID contents (0 = bubble)
//     PC_IF_ID, PCPlus4_IF_ID          - address of the IF/ID word and +4
//     Rs_IF_ID, Rt_IF_ID               - register fields of Instr_IF_ID
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Load_Use,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] Redirect_PC,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              Valid_IF_ID,
   output logic [31:0]       Instr_IF_ID,
   output logic [ADDR_W-1:0] PC_IF_ID,
   output logic [ADDR_W-1:0] PCPlus4_IF_ID,
   output logic [4:0]        Rs_IF_ID,
   output logic [4:0]        Rt_IF_ID
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] r_req_pc;

   logic              w_req_valid;
   logic              w_accept;
   logic              w_rsp_live;
   logic              w_buf_load;
   logic              w_buf_clear;
   logic              w_buf_full;
   logic [31:0]       w_buf_data;
   logic [ADDR_W-1:0] w_buf_pc;

   logic              r_valid_id;
   logic [31:0]       r_instr_id;
   logic [ADDR_W-1:0] r_pc_id;
   logic [ADDR_W-1:0] r_pcp4_id;

   // Request generation: a flush or stall suppresses issue; otherwise issue
   // in S_REQ, or back-to-back in S_WAIT when the current response arrives.
   always_comb begin
      w_req_valid = 1'b0;
      if (Redirect || Load_Use) begin
         w_req_valid = 1'b0;
      end else begin
         case (r_state)
            S_REQ:   w_req_valid = 1'b1;
            S_WAIT:  w_req_valid = imem_rsp_valid;
            default: w_req_valid = 1'b0;
         endcase
      end
   end

   assign w_accept = w_req_valid & imem_req_ready;

   // A response only counts while in S_WAIT; in S_DROP it is from a flushed path.
   assign w_rsp_live = (r_state == S_WAIT) & imem_rsp_valid;

   // Park a live response when ID is stalled; empty on flush or once drained.
   assign w_buf_load  = w_rsp_live & Load_Use & ~Redirect;
   assign w_buf_clear = Redirect | (w_buf_full & ~Load_Use);

   // Next-state logic for the fetch controller.
   always_comb begin
      w_state_nxt = r_state;
      if (Redirect) begin
         // A still-pending response must be swallowed before fetching anew;
         // one arriving right now is simply ignored.
         if (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rsp_valid) begin
            w_state_nxt = S_DROP;
         end else begin
            w_state_nxt = S_REQ;
         end
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_accept) begin
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_WAIT: begin
               if (!imem_rsp_valid) begin
                  w_state_nxt = S_WAIT;
               end else if (Load_Use) begin
                  w_state_nxt = S_HOLD;
               end else if (w_accept) begin
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_HOLD: begin
               if (Load_Use) begin
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rsp_valid) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_DROP;
               end
            end
            default: w_state_nxt = S_REQ;
         endcase
      end
   end

   // Next PC: redirect target, else advance on accept (wraps naturally).
   always_comb begin
      w_pc_nxt = r_pc;
      if (Redirect) begin
         w_pc_nxt = Redirect_PC;
      end else if (w_accept) begin
         w_pc_nxt = r_pc + PC_STEP;
      end else begin
         w_pc_nxt = r_pc;
      end
   end

   // Fetch controller state and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Address of the outstanding request, so IF/ID gets the right PC even
   // when the next request is accepted in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_pc <= {ADDR_W{1'b0}};
      end else if (w_accept) begin
         r_req_pc <= r_pc;
      end
   end

   if_skid_buffer #(
      .ADDR_W (ADDR_W)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_buf_load),
      .i_clear (w_buf_clear),
      .i_data  (imem_rsp_data),
      .i_pc    (r_req_pc),
      .o_full  (w_buf_full),
      .o_data  (w_buf_data),
      .o_pc    (w_buf_pc)
   );

   // IF/ID register: flush > stall (hold) > buffered word > live response > bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_id <= 1'b0;
         r_instr_id <= NOP;
         r_pc_id    <= {ADDR_W{1'b0}};
         r_pcp4_id  <= {ADDR_W{1'b0}};
      end else if (Redirect) begin
         r_valid_id <= 1'b0;
         r_instr_id <= NOP;
         r_pc_id    <= {ADDR_W{1'b0}};
         r_pcp4_id  <= {ADDR_W{1'b0}};
      end else if (!Load_Use) begin
         if (w_buf_full) begin
            r_valid_id <= 1'b1;
            r_instr_id <= w_buf_data;
            r_pc_id    <= w_buf_pc;
            r_pcp4_id  <= w_buf_pc + PC_STEP;
         end else if (w_rsp_live) begin
            r_valid_id <= 1'b1;
            r_instr_id <= imem_rsp_data;
            r_pc_id    <= r_req_pc;
            r_pcp4_id  <= r_req_pc + PC_STEP;
         end else begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP;
            r_pc_id    <= {ADDR_W{1'b0}};
            r_pcp4_id  <= {ADDR_W{1'b0}};
         end
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_pc;
   assign Valid_IF_ID    = r_valid_id;
   assign Instr_IF_ID    = r_instr_id;
   assign PC_IF_ID       = r_pc_id;
   assign PCPlus4_IF_ID  = r_pcp4_id;
   // Bubbles carry NOP, so these read 0 whenever IF/ID is empty.
   assign Rs_IF_ID       = instr_rs(r_instr_id);
   assign Rt_IF_ID       = instr_rt(r_instr_id);

endmodule
